// File: rtl/shift_add_mult_ctrl.sv
// ---------------------------------------------------------------------------
// shift_add_mult_ctrl
//   Sequential unsigned multiplier built from one WIDTH+1-bit adder. It
//   performs one add-and-shift step per clock and needs WIDTH clocks per
//   product.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; operands are captured when start is accepted
//   RUN   | one add/shift step per edge; WIDTH steps in total
//   DONE  | product valid and newly updated; done pulses for this cycle
//
// Ports
//   clk      in   1        system clock, rising edge
//   rst      in   1        synchronous active-high reset
//   start    in   1        begin a multiply (sampled only in IDLE)
//   a        in   WIDTH    multiplicand, unsigned
//   b        in   WIDTH    multiplier, unsigned
//   busy     out  1        operation in progress (RUN or DONE)
//   done     out  1        one-cycle pulse, product just updated
//   product  out  2*WIDTH  result of the last completed operation
// ---------------------------------------------------------------------------
module shift_add_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]         state_q,   state_d;
  logic [WIDTH-1:0]   mcand_q,   mcand_d;
  logic [WIDTH:0]     acc_q,     acc_d;
  logic [WIDTH-1:0]   mplier_q,  mplier_d;
  logic [CW-1:0]      count_q,   count_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  // The shared adder. acc never exceeds 2^WIDTH-1 after a shift, so the
  // WIDTH+1-bit sum always holds the carry out of the WIDTH-bit add.
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   shifted;

  always_comb begin
    addend  = mplier_q[0] ? {1'b0, mcand_q} : '0;
    sum     = acc_q + addend;
    // The carry (sum MSB) shifts into acc, and the sum LSB shifts into the
    // top of mplier as the next finished product bit.
    shifted = {sum, mplier_q} >> 1;
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    product_d = product_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          count_d  = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        acc_d    = shifted[2*WIDTH:WIDTH];
        mplier_d = shifted[WIDTH-1:0];
        count_d  = count_q + 1'b1;
        if (count_q == LAST_STEP) begin
          product_d = {acc_d[WIDTH-1:0], mplier_d};
          state_d   = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  // Status comes from the state register only.
  assign busy    = (state_q == RUN) || (state_q == DONE);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule
